arbiter_requester: RTL and testbench

- Client-side agent for one position in the expandable daisy-chain arbiter. It drives the cell's request input `r` and consumes the cell's grant output `g`.
- Accepts a transfer job from local logic over a valid/ready handshake and holds the request across a multi-beat bus tenure. It releases the chain with a guaranteed holdoff so downstream cells can win, and aborts on wait timeout.
- One instance per chain position; `g` is the combinational `cin & r` from that position's cell.

---
 rtl/arbiter_pkg.sv | 27 ++
 rtl/sat_counter.sv | 23 ++
 rtl/arbiter_requester.sv | 118 +++++++++++
 tb/tb_arbiter_requester.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and defaults for the daisy-chain arbiter requester.
package arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OWN  = 2'd2,
    REL  = 2'd3
  } req_state_t;

  localparam int DEF_MAX_BEATS = 32'sd16;
  localparam int DEF_TIMEOUT   = 32'sd64;
  localparam int DEF_HOLDOFF   = 32'sd1;

  // A zero-length job still occupies one beat; oversized jobs are clamped.
  function automatic int unsigned normalize_len(input int unsigned len,
                                                input int unsigned max_beats);
    if (len == 32'd0) begin
      return 32'd1;
    end else if (len > max_beats) begin
      return max_beats;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up, stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1'b1);
    end
  end

endmodule

// File: rtl/arbiter_requester.sv
// Client agent for one daisy-chain arbiter position: holds r across a
// multi-beat tenure, releases with a holdoff, aborts on grant timeout.
module arbiter_requester
  import arbiter_pkg::*;
#(
  parameter int MAX_BEATS = DEF_MAX_BEATS,
  parameter int CNT_W     = $clog2(MAX_BEATS + 32'sd1),
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int HOLDOFF   = DEF_HOLDOFF,
  parameter int WAIT_W    = 32'sd16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [CNT_W-1:0]  job_len,
  output logic              r,
  input  logic              g,
  output logic              bus_en,
  output logic [CNT_W-1:0]  beat_idx,
  output logic              done,
  output logic              timeout,
  output logic [WAIT_W-1:0] wait_cycles
);

  localparam int HOLD_W = (HOLDOFF > 32'sd1) ? $clog2(HOLDOFF) : 32'sd1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLDOFF - 32'sd1);
  localparam logic [WAIT_W-1:0] TO_LAST   = WAIT_W'(TIMEOUT - 32'sd1);
  localparam logic              TO_EN     = (TIMEOUT != 32'sd0);

  req_state_t        state_r;
  logic [CNT_W-1:0]  len_r;
  logic [CNT_W-1:0]  beat_r;
  logic [HOLD_W-1:0] hold_r;
  logic              done_r;
  logic              timeout_r;
  logic              wait_clr_s;
  logic              wait_inc_s;
  logic [CNT_W-1:0]  norm_len_s;

  assign norm_len_s = CNT_W'(normalize_len(32'(job_len), int'(MAX_BEATS)));

  // Outputs seen by the chain decode state only, so no path runs from g to r.
  assign r         = (state_r == REQ) || (state_r == OWN);
  assign job_ready = (state_r == IDLE);
  assign bus_en    = (state_r == OWN) && g;
  assign beat_idx  = beat_r;
  assign done      = done_r;
  assign timeout   = timeout_r;

  assign wait_clr_s = (state_r == IDLE) && job_valid;
  assign wait_inc_s = ((state_r == REQ) || (state_r == OWN)) && !g;

  sat_counter #(.W(WAIT_W)) u_wait (
    .clk   (clk),
    .rst   (rst),
    .clr   (wait_clr_s),
    .inc   (wait_inc_s),
    .count (wait_cycles)
  );

  // Tenure state machine with registered done/timeout pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      len_r     <= '0;
      beat_r    <= '0;
      hold_r    <= '0;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (job_valid) begin
            len_r   <= norm_len_s;
            beat_r  <= '0;
            state_r <= REQ;
          end
        end
        REQ: begin
          if (g) begin
            beat_r  <= '0;
            state_r <= OWN;
          end else if (TO_EN && (wait_cycles == TO_LAST)) begin
            timeout_r <= 1'b1;
            state_r   <= IDLE;
          end
        end
        OWN: begin
          // A g=0 cycle here is an upstream preemption: stall in place.
          if (g) begin
            if (beat_r == (len_r - CNT_W'(1'b1))) begin
              beat_r  <= '0;
              hold_r  <= HOLD_INIT;
              done_r  <= 1'b1;
              state_r <= REL;
            end else begin
              beat_r <= beat_r + CNT_W'(1'b1);
            end
          end
        end
        REL: begin
          if (hold_r == '0) begin
            state_r <= IDLE;
          end else begin
            hold_r <= hold_r - HOLD_W'(1'b1);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter_requester.sv
// Two chained requesters behind behavioural arbiter cells, checked every cycle
// against a job-level model plus directed literal scenarios.
module tb_arbiter_requester;

  localparam int TO   = 8;
  localparam int MAXB = 16;
  localparam int HO   = 1;
  localparam int WMAX = 65535;

  logic        clk;
  logic        rst;
  logic        cin0;
  logic        cin1;
  logic        g0;
  logic        g1;
  logic [1:0]  jv;
  logic [4:0]  jl [2];
  logic [1:0]  d_ready;
  logic [1:0]  d_r;
  logic [1:0]  d_bus;
  logic [1:0]  d_done;
  logic [1:0]  d_to;
  logic [4:0]  d_idx [2];
  logic [15:0] d_wait [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Job-level model state per position.
  int m_pend [2];
  int m_taken [2];
  int m_hold [2];
  int m_wait [2];
  bit m_gr [2];
  bit m_done [2];
  bit m_to [2];

  int e1_r     [6] = '{1, 1, 1, 1, 0, 0};
  int e1_bus   [6] = '{0, 1, 1, 1, 0, 0};
  int e1_idx   [6] = '{0, 0, 1, 2, 0, 0};
  int e1_done  [6] = '{0, 0, 0, 0, 1, 0};
  int e1_ready [6] = '{0, 0, 0, 0, 0, 1};
  int ep_cin   [8] = '{1, 1, 1, 0, 0, 1, 1, 1};
  int ep_bus   [8] = '{0, 1, 1, 0, 0, 1, 1, 0};
  int ep_idx   [8] = '{0, 0, 1, 0, 0, 2, 3, 0};
  int ep_done  [8] = '{0, 0, 0, 0, 0, 0, 0, 1};

  // Daisy-chain cells: g = cin & r, cout = cin & ~r.
  assign g0   = cin0 & d_r[0];
  assign cin1 = cin0 & ~d_r[0];
  assign g1   = cin1 & d_r[1];

  arbiter_requester #(.TIMEOUT(TO)) u0 (
    .clk(clk), .rst(rst), .job_valid(jv[0]), .job_ready(d_ready[0]), .job_len(jl[0]),
    .r(d_r[0]), .g(g0), .bus_en(d_bus[0]), .beat_idx(d_idx[0]), .done(d_done[0]),
    .timeout(d_to[0]), .wait_cycles(d_wait[0])
  );

  arbiter_requester #(.TIMEOUT(TO)) u1 (
    .clk(clk), .rst(rst), .job_valid(jv[1]), .job_ready(d_ready[1]), .job_len(jl[1]),
    .r(d_r[1]), .g(g1), .bus_en(d_bus[1]), .beat_idx(d_idx[1]), .done(d_done[1]),
    .timeout(d_to[1]), .wait_cycles(d_wait[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit m_r(input int i);
    return m_pend[i] > 0;
  endfunction

  function automatic bit m_g(input int i);
    if (i == 0) return cin0 && m_r(0);
    return cin0 && !m_r(0) && m_r(1);
  endfunction

  function automatic int norm(input int len);
    if (len == 0) return 1;
    if (len > MAXB) return MAXB;
    return len;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_taken[i] = 0; m_hold[i] = 0; m_wait[i] = 0;
      m_gr[i] = 1'b0; m_done[i] = 1'b0; m_to[i] = 1'b0;
    end
  endtask

  task automatic m_step(input int i, input bit gi);
    m_done[i] = 1'b0;
    m_to[i]   = 1'b0;
    if (m_pend[i] > 0) begin
      if (!m_gr[i]) begin
        if (gi) m_gr[i] = 1'b1;
        else begin
          if (m_wait[i] < WMAX) m_wait[i]++;
          if (TO != 0 && m_wait[i] == TO) begin
            m_pend[i] = 0;
            m_to[i]   = 1'b1;
          end
        end
      end else if (gi) begin
        m_taken[i]++;
        m_pend[i]--;
        if (m_pend[i] == 0) begin
          m_done[i] = 1'b1;
          m_hold[i] = HO;
        end
      end else if (m_wait[i] < WMAX) begin
        m_wait[i]++;
      end
    end else if (m_hold[i] > 0) begin
      m_hold[i]--;
    end else if (jv[i]) begin
      m_pend[i]  = norm(int'(jl[i]));
      m_taken[i] = 0;
      m_gr[i]    = 1'b0;
      m_wait[i]  = 0;
    end
  endtask

  // Model advance on every rising edge (held in reset while rst is high).
  initial begin
    m_reset();
    forever begin
      @(posedge clk);
      if (rst) m_reset();
      else begin
        bit gs0, gs1;
        gs0 = m_g(0);
        gs1 = m_g(1);
        m_step(0, gs0);
        m_step(1, gs1);
      end
    end
  end

  // Compare process: every falling edge, both positions.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 2; i++) begin
          bit eb;
          eb = m_r(i) && m_gr[i] && m_g(i);
          chk($sformatf("u%0d.r", i), int'(d_r[i]), int'(m_r(i)));
          chk($sformatf("u%0d.job_ready", i), int'(d_ready[i]),
              int'(m_pend[i] == 0 && m_hold[i] == 0));
          chk($sformatf("u%0d.bus_en", i), int'(d_bus[i]), int'(eb));
          if (eb) chk($sformatf("u%0d.beat_idx", i), int'(d_idx[i]), m_taken[i]);
          chk($sformatf("u%0d.done", i), int'(d_done[i]), int'(m_done[i]));
          chk($sformatf("u%0d.timeout", i), int'(d_to[i]), int'(m_to[i]));
          chk($sformatf("u%0d.wait_cycles", i), int'(d_wait[i]), m_wait[i]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job0(input int len, output int beats, output int last, output bit ok);
    beats = 0; last = -1; ok = 1'b0;
    jv[0] = 1'b1; jl[0] = 5'(len);
    cyc();
    jv[0] = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (d_bus[0]) begin
        beats++;
        last = int'(d_idx[0]);
      end
      if (d_done[0]) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    cyc();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int beats, last, n;
    bit ok;
    rst = 1'b1; cin0 = 1'b1; jv = 2'b00; jl[0] = 5'd0; jl[1] = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.r", int'(d_r[0]), 0);
    chk("reset.job_ready", int'(d_ready[0]), 1);
    chk("reset.bus_en", int'(d_bus[0]), 0);
    chk("reset.beat_idx", int'(d_idx[0]), 0);
    chk("reset.done", int'(d_done[0]), 0);
    chk("reset.timeout", int'(d_to[0]), 0);
    chk("reset.wait", int'(d_wait[0]), 0);
    rst = 1'b0;
    #1 chk_en = 1'b1;
    cyc();

    // len=3 at the top of the chain.
    jv[0] = 1'b1; jl[0] = 5'd3;
    @(negedge clk);
    chk("t1.ready_idle", int'(d_ready[0]), 1);
    chk("t1.r_idle", int'(d_r[0]), 0);
    cyc();
    jv[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("t1.r[%0d]", k), int'(d_r[0]), e1_r[k]);
      chk($sformatf("t1.bus_en[%0d]", k), int'(d_bus[0]), e1_bus[k]);
      if (e1_bus[k] != 0) chk($sformatf("t1.beat_idx[%0d]", k), int'(d_idx[0]), e1_idx[k]);
      chk($sformatf("t1.done[%0d]", k), int'(d_done[0]), e1_done[k]);
      chk($sformatf("t1.job_ready[%0d]", k), int'(d_ready[0]), e1_ready[k]);
      cyc();
    end

    // len=0 and len=20 normalisation.
    run_job0(0, beats, last, ok);
    chk("len0.done_seen", int'(ok), 1);
    chk("len0.beats", beats, 1);
    chk("len0.last_idx", last, 0);
    run_job0(20, beats, last, ok);
    chk("len20.done_seen", int'(ok), 1);
    chk("len20.beats", beats, 16);
    chk("len20.last_idx", last, 15);

    // Grant withheld: timeout after TO request cycles.
    cin0 = 1'b0;
    jv[0] = 1'b1; jl[0] = 5'd2;
    cyc();
    jv[0] = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!d_r[0]) break;
      n++;
      cyc();
    end
    chk("to.r_cycles", n, 8);
    chk("to.timeout", int'(d_to[0]), 1);
    chk("to.wait", int'(d_wait[0]), 8);
    chk("to.done", int'(d_done[0]), 0);
    chk("to.ready", int'(d_ready[0]), 1);
    cyc();
    @(negedge clk);
    chk("to.pulse_once", int'(d_to[0]), 0);
    cin0 = 1'b1;
    cyc();

    // Preemption in OWN after beat 1.
    jv[0] = 1'b1; jl[0] = 5'd4;
    cyc();
    jv[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cin0 = (ep_cin[k] != 0);
      @(negedge clk);
      chk($sformatf("pre.bus_en[%0d]", k), int'(d_bus[0]), ep_bus[k]);
      if (ep_bus[k] != 0) chk($sformatf("pre.beat_idx[%0d]", k), int'(d_idx[0]), ep_idx[k]);
      chk($sformatf("pre.done[%0d]", k), int'(d_done[0]), ep_done[k]);
      if (k == 7) chk("pre.wait", int'(d_wait[0]), 2);
      cyc();
    end
    cin0 = 1'b1;
    cyc();

    // Downstream client granted as soon as upstream releases.
    jv = 2'b11; jl[0] = 5'd2; jl[1] = 5'd1;
    cyc();
    jv = 2'b00;
    ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (d_done[0]) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    chk("chain.done0_seen", int'(ok), 1);
    chk("chain.g1_at_rel", int'(g1), 1);
    cyc();
    @(negedge clk);
    chk("chain.bus_en1", int'(d_bus[1]), 1);
    chk("chain.beat_idx1", int'(d_idx[1]), 0);
    repeat (4) cyc();

    // Asynchronous reset in the middle of a tenure.
    jv[0] = 1'b1; jl[0] = 5'd5;
    cyc();
    jv[0] = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (d_bus[0]) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    chk("arst.owning", int'(ok), 1);
    chk_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst.r", int'(d_r[0]), 0);
    chk("arst.bus_en", int'(d_bus[0]), 0);
    chk("arst.job_ready", int'(d_ready[0]), 1);
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    chk_en = 1'b1;
    cyc();
    @(negedge clk);
    chk("arst.ready_after", int'(d_ready[0]), 1);
    chk("arst.r_after", int'(d_r[0]), 0);

    // Randomised traffic on both positions.
    for (int c = 0; c < 3000; c++) begin
      cyc();
      jv[0] = ($urandom % 3) == 0;
      jv[1] = ($urandom % 3) == 0;
      jl[0] = 5'($urandom_range(0, 31));
      jl[1] = 5'($urandom_range(0, 31));
      cin0  = ($urandom % 8) != 0;
    end
    jv = 2'b00;
    cin0 = 1'b1;
    repeat (40) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
